// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV M-extension multiply/divide unit
// Optional build macro: MULDIV_FAST_MUL_EN (single-cycle combinational multiply path)
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_CORR,
    S_DONE
  } state_t;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [2*XLEN-1:0]   acc;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [XLEN-1:0]     opb;
  logic [2:0]          op_q;
  logic [4:0]          tag_q;
  logic                neg_q;
  logic                fast_q;
  logic                busy_q;
  logic                valid_q;
  logic [XLEN-1:0]     result_q;
  logic [4:0]          rd_q;

  // Acceptance-time decode of operand signedness, magnitudes and fast paths
  logic                is_div_in;
  logic                op1_signed;
  logic                op2_signed;
  logic                s1;
  logic                s2;
  logic [XLEN-1:0]     mag1;
  logic [XLEN-1:0]     mag2;
  logic                neg_in;
  logic                div_zero;
  logic                div_ovf;
  logic                fast_mul;
  logic                fast_in;
  logic [XLEN-1:0]     fast_res;
  logic [XLEN-1:0]     fast_mul_res;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0]   fm_a;
  logic [2*XLEN-1:0]   fm_b;
  logic [2*XLEN-1:0]   fm_p;

  // Sign-extend to 2*XLEN so the low 2*XLEN bits of the product are exact
  always_comb begin
    fm_a = {{XLEN{op1_signed & op1_i[XLEN-1]}}, op1_i};
    fm_b = {{XLEN{op2_signed & op2_i[XLEN-1]}}, op2_i};
    fm_p = fm_a * fm_b;
    fast_mul_res = (op_i == OP_MUL) ? fm_p[XLEN-1:0] : fm_p[2*XLEN-1:XLEN];
    fast_mul = ~op_i[2];
  end
`else
  assign fast_mul_res = '0;
  assign fast_mul     = 1'b0;
`endif

  // Decode operands presented with start_i
  always_comb begin
    is_div_in  = op_i[2];
    op1_signed = (op_i != OP_MULHU) && (op_i != OP_DIVU) && (op_i != OP_REMU);
    op2_signed = (op_i == OP_MUL) || (op_i == 3'd1) || (op_i == OP_DIV) || (op_i == OP_REM);
    s1         = op1_signed & op1_i[XLEN-1];
    s2         = op2_signed & op2_i[XLEN-1];
    mag1       = s1 ? -op1_i : op1_i;
    mag2       = s2 ? -op2_i : op2_i;
    // Remainder follows the dividend; everything else is negative when signs differ
    neg_in     = (op_i == OP_REM) ? s1 : (s1 ^ s2);
    div_zero   = is_div_in && (op2_i == '0);
    div_ovf    = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                 (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == '1);
    fast_in    = div_zero | div_ovf | fast_mul;
    fast_res   = fast_mul_res;
    if (div_zero) begin
      fast_res = op_i[1] ? op1_i : '1;
    end else if (div_ovf) begin
      fast_res = op_i[1] ? '0 : op1_i;
    end
  end

  // One iteration of shift-add multiply and restoring divide
  logic [XLEN:0]       add_sum;
  logic [2*XLEN-1:0]   mul_next;
  logic [XLEN:0]       partial;
  logic [XLEN+1:0]     diff;
  logic [2*XLEN-1:0]   div_next;

  always_comb begin
    add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
    mul_next = {add_sum, acc[XLEN-1:1]};
    partial  = acc[2*XLEN-1:XLEN-1];
    diff     = {1'b0, partial} - {2'b00, opb};
    if (diff[XLEN+1]) begin
      div_next = {partial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      div_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end
  end

  // Sign correction and result selection applied while in CORR
  logic [2*XLEN-1:0]   prod_c;
  logic [XLEN-1:0]     quo_c;
  logic [XLEN-1:0]     rem_c;
  logic [XLEN-1:0]     corr_res;

  always_comb begin
    prod_c = neg_q ? -acc : acc;
    quo_c  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_c  = neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:           corr_res = prod_c[XLEN-1:0];
      OP_DIV, OP_DIVU:  corr_res = quo_c;
      OP_REM, OP_REMU:  corr_res = rem_c;
      default:          corr_res = prod_c[2*XLEN-1:XLEN];
    endcase
  end

  // Control FSM with datapath registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      opb      <= '0;
      op_q     <= '0;
      tag_q    <= '0;
      neg_q    <= 1'b0;
      fast_q   <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
    end else if (flush_i) begin
      state   <= S_IDLE;
      cnt     <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          valid_q <= 1'b0;
          if (start_i) begin
            state  <= S_CALC;
            busy_q <= 1'b1;
            cnt    <= CNT_W'(XLEN);
            op_q   <= op_i;
            tag_q  <= rd_i;
            neg_q  <= neg_in;
            fast_q <= fast_in;
            opb    <= is_div_in ? mag2 : mag1;
            if (fast_in) begin
              acc <= {{XLEN{1'b0}}, fast_res};
            end else begin
              acc <= {{XLEN{1'b0}}, (is_div_in ? mag1 : mag2)};
            end
          end
        end
        S_CALC: begin
          if (fast_q) begin
            state    <= S_DONE;
            valid_q  <= 1'b1;
            result_q <= acc[XLEN-1:0];
            rd_q     <= tag_q;
          end else if (cnt != '0) begin
            acc <= op_q[2] ? div_next : mul_next;
            cnt <= cnt - CNT_W'(1);
          end else begin
            state <= S_CORR;
          end
        end
        S_CORR: begin
          state    <= S_DONE;
          valid_q  <= 1'b1;
          result_q <= corr_res;
          rd_q     <= tag_q;
        end
        S_DONE: begin
          state   <= S_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
        default: begin
          state   <= S_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  // A flush arriving in DONE suppresses the pulse in that same cycle
  assign valid_o  = valid_q & ~flush_i;
  assign result_o = result_q;
  assign rd_o     = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;

  localparam int XL = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int ML = 1;
`else
  localparam int ML = XL + 2;
`endif
  localparam int DL = XL + 2;

  logic          clk;
  logic          rst_n;
  logic          start_i;
  logic [2:0]    op_i;
  logic [XL-1:0] op1_i;
  logic [XL-1:0] op2_i;
  logic [4:0]    rd_i;
  logic          flush_i;
  logic          busy_o;
  logic          valid_o;
  logic [XL-1:0] result_o;
  logic [4:0]    rd_o;

  muldiv_unit #(.XLEN(XL)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .op_i     (op_i),
    .op1_i    (op1_i),
    .op2_i    (op2_i),
    .rd_i     (rd_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .result_o (result_o),
    .rd_o     (rd_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    op;
    logic [XL-1:0] a;
    logic [XL-1:0] b;
    logic [4:0]    rd;
    logic [XL-1:0] exp;
    int            lat;
  } vec_t;

  typedef struct packed {
    logic [XL-1:0] res;
    logic [4:0]    rd;
  } exp_t;

  vec_t vecs[18];
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   valid_cnt = 0;

  task automatic check(input string name, input logic [XL-1:0] act, input logic [XL-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && valid_o) begin
      exp_t e;
      valid_cnt++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid actual=%h rd=%0d required=none", result_o, rd_o);
      end else begin
        e = sb_q.pop_front();
        if (result_o !== e.res || rd_o !== e.rd) begin
          errors++;
          $display("FAIL scoreboard actual=%h/%0d required=%h/%0d", result_o, rd_o, e.res, e.rd);
        end
      end
    end
  end

  function automatic logic [XL-1:0] model(input logic [2:0] op, input logic [XL-1:0] a, input logic [XL-1:0] b);
    longint      sa, sb, r;
    logic [63:0] ua, ub, pu;
    logic        ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = 0;
    pu  = '0;
    case (op)
      3'd0: begin r = sa * sb; return r[31:0]; end
      3'd1: begin r = sa * sb; return r[63:32]; end
      3'd2: begin r = sa * longint'(ub); return r[63:32]; end
      3'd3: begin pu = ua * ub; return pu[63:32]; end
      3'd4: begin
        if (b == '0) return '1;
        if (ovf) return a;
        r = sa / sb; return r[31:0];
      end
      3'd5: begin
        if (b == '0) return '1;
        pu = ua / ub; return pu[31:0];
      end
      3'd6: begin
        if (b == '0) return a;
        if (ovf) return '0;
        r = sa % sb; return r[31:0];
      end
      default: begin
        if (b == '0) return a;
        pu = ua % ub; return pu[31:0];
      end
    endcase
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [XL-1:0] a, input logic [XL-1:0] b,
                        input logic [4:0] rd, input logic [XL-1:0] req, input int lat, input string name);
    int n;
    bit got;
    @(negedge clk);
    op_i    = op;
    op1_i   = a;
    op2_i   = b;
    rd_i    = rd;
    start_i = 1'b1;
    sb_q.push_back('{res: req, rd: rd});
    @(posedge clk);
    #1 start_i = 1'b0;
    n   = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (valid_o) got = 1'b1;
    end
    checks++;
    if (!got || n != lat) begin
      errors++;
      $display("FAIL %s_latency actual=%0d required=%0d", name, got ? n : -1, lat);
    end
    @(posedge clk);
    #1;
    check({name, "_held"}, result_o, req);
    check({name, "_idle"}, {31'b0, busy_o}, 32'd0);
  endtask

  initial begin
    int v0;
    int n;
    bit got;
    logic [2:0]    rop;
    logic [XL-1:0] ra, rb;
    int            rlat;

    vecs[0]  = '{3'd0, 32'd3,          32'd5,          5'd1,  32'd15,         ML};
    vecs[1]  = '{3'd0, 32'hFFFF_FFFF,  32'd2,          5'd2,  32'hFFFF_FFFE,  ML};
    vecs[2]  = '{3'd1, 32'h8000_0000,  32'h8000_0000,  5'd3,  32'h4000_0000,  ML};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd4,  32'hFFFF_FFFF,  ML};
    vecs[4]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd5,  32'hFFFF_FFFE,  ML};
    vecs[5]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd6,  32'h0,          ML};
    vecs[6]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,          5'd7,  32'hFFFF_FFFD,  DL};
    vecs[7]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,          5'd8,  32'hFFFF_FFFF,  DL};
    vecs[8]  = '{3'd5, 32'd100,        32'd7,          5'd9,  32'd14,         DL};
    vecs[9]  = '{3'd7, 32'd100,        32'd7,          5'd10, 32'd2,          DL};
    vecs[10] = '{3'd4, 32'd7,          32'hFFFF_FFFE,  5'd11, 32'hFFFF_FFFD,  DL};
    vecs[11] = '{3'd6, 32'd7,          32'hFFFF_FFFE,  5'd12, 32'd1,          DL};
    vecs[12] = '{3'd5, 32'h1234,       32'd0,          5'd13, 32'hFFFF_FFFF,  1};
    vecs[13] = '{3'd7, 32'h1234,       32'd0,          5'd14, 32'h1234,       1};
    vecs[14] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  5'd15, 32'h8000_0000,  1};
    vecs[15] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  5'd16, 32'h0,          1};
    vecs[16] = '{3'd6, 32'hFFFF_FFFB,  32'd0,          5'd17, 32'hFFFF_FFFB,  1};
    vecs[17] = '{3'd2, 32'd2,          32'hFFFF_FFFF,  5'd18, 32'd1,          ML};

    rst_n   = 1'b0;
    start_i = 1'b0;
    flush_i = 1'b0;
    op_i    = '0;
    op1_i   = '0;
    op2_i   = '0;
    rd_i    = '0;
    #12;
    check("reset_busy",   {31'b0, busy_o},  32'd0);
    check("reset_valid",  {31'b0, valid_o}, 32'd0);
    check("reset_result", result_o,         32'd0);
    check("reset_rd",     {27'b0, rd_o},    32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].lat,
             $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (i == 3) ? 32'd0 : $urandom;
      if (!rop[2]) rlat = ML;
      else if (rb == '0 || (rop[1:0] != 2'b01 && rop[1:0] != 2'b11 &&
               ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)) rlat = 1;
      else rlat = DL;
      run_op(rop, ra, rb, 5'(20 + i), model(rop, ra, rb), rlat, $sformatf("rnd%0d", i));
    end

    // Flush a divide at A+10, then a multiply in the next idle cycle
    @(negedge clk);
    op_i = 3'd5; op1_i = 32'h1234; op2_i = 32'd3; rd_i = 5'd30; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    check("flush_busy", {31'b0, busy_o}, 32'd0);
    run_op(3'd0, 32'd3, 32'd5, 5'd31, 32'd15, ML, "after_flush");

    // Flush coinciding with DONE must gate valid_o in that cycle
    @(negedge clk);
    op_i = 3'd5; op1_i = 32'h55; op2_i = 32'd0; rd_i = 5'd29; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    @(posedge clk);
    #1 flush_i = 1'b1;
    #1;
    check("done_flush_valid", {31'b0, valid_o}, 32'd0);
    @(posedge clk);
    #1 flush_i = 1'b0;
    check("done_flush_busy", {31'b0, busy_o}, 32'd0);

    // Reset mid-operation clears outputs at once; first edge after release accepts
    @(negedge clk);
    op_i = 3'd5; op1_i = 32'd100; op2_i = 32'd7; rd_i = 5'd28; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy",   {31'b0, busy_o},  32'd0);
    check("rst_valid",  {31'b0, valid_o}, 32'd0);
    check("rst_result", result_o,         32'd0);
    check("rst_rd",     {27'b0, rd_o},    32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    run_op(3'd3, 32'h1_0000, 32'h3_0000, 5'd27, 32'd3, ML, "after_reset");

    // start_i held high through a busy operation gives exactly one result
    v0 = valid_cnt;
    @(negedge clk);
    op_i = 3'd0; op1_i = 32'd6; op2_i = 32'd7; rd_i = 5'd26; start_i = 1'b1;
    sb_q.push_back('{res: 32'd42, rd: 5'd26});
    @(posedge clk);
    #1 op1_i = 32'd9;
    n = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (valid_o) got = 1'b1;
    end
    start_i = 1'b0;
    checks++;
    if (!got || n != ML) begin
      errors++;
      $display("FAIL held_start_latency actual=%0d required=%0d", got ? n : -1, ML);
    end
    repeat (6) @(posedge clk);
    #1;
    check("held_start_count", 32'(valid_cnt - v0), 32'd1);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values 8..64, even.
REQ-002 Parameter CNT_W, default $clog2(XLEN)+1, iteration counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start_i  input  1  request strobe; sampled only in IDLE.
REQ-006 op_i  input  3  RV M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 op1_i, op2_i  input  XLEN  rs1/rs2 operands.
REQ-008 rd_i  input  5  destination register tag.
REQ-009 flush_i  input  1  abort in-flight operation (jump/branch redirect).
REQ-010 busy_o  output  1  high in every state except IDLE.
REQ-011 valid_o  output  1  one-cycle result-valid pulse.
REQ-012 result_o  output  XLEN  result; held stable until next acceptance.
REQ-013 rd_o  output  5  tag captured at acceptance.

Function
REQ-014 States: IDLE, CALC, CORR, DONE; encoding free.
REQ-015 Acceptance: start_i=1 and flush_i=0 in IDLE; op, operands, tag captured at that edge (edge A).
REQ-016 start_i while busy_o=1 SHALL be ignored; no queueing.
REQ-017 Signed ops (MUL, MULH, DIV, REM; op1 of MULHSU) SHALL convert to magnitudes at acceptance and record result sign.
REQ-018 CALC SHALL iterate one bit per cycle for exactly XLEN cycles: shift-add multiply to 2*XLEN product, restoring division to XLEN quotient and remainder.
REQ-019 CORR (one cycle) SHALL apply two's-complement negation: product if operand signs differ; quotient if signs differ; remainder takes dividend sign.
REQ-020 MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2*XLEN-1:XLEN].
REQ-021 DONE lasts one cycle with valid_o=1, then IDLE; normal latency: valid_o high in cycle XLEN+2 after edge A.
REQ-022 Divide by zero: skip CALC/CORR, go to DONE at edge A+1; DIV/DIVU = all ones, REM/REMU = op1.
REQ-023 Signed overflow (op1 = -2^(XLEN-1), op2 = -1): DIV = op1, REM = 0, same one-cycle fast path.
REQ-024 flush_i=1 in any state SHALL force IDLE at next edge; valid_o SHALL not assert for the aborted operation, including when flush_i coincides with DONE (valid_o gated low that cycle).
REQ-025 flush_i and start_i together in IDLE: flush wins, no acceptance.
REQ-026 Back-to-back: new start_i accepted in the cycle after DONE (IDLE), giving one idle cycle between results.
REQ-027 result_o and rd_o update only on the edge entering DONE.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, busy_o=0, valid_o=0, result_o=0, rd_o=0, counter=0, independent of clk.
REQ-029 Reset asserted mid-operation SHALL discard the operation; no valid_o after release.
REQ-030 First acceptance possible at the first rising edge after rst_n deasserts.

Configuration
REQ-031 Macro MULDIV_FAST_MUL_EN defined: MUL* ops computed with one combinational XLEN x XLEN multiplier, bypassing CALC/CORR, valid_o at cycle A+1; divide unchanged.
REQ-032 Macro undefined: all MUL* ops use iterative path of REQ-018, latency XLEN+2; no wide multiplier instantiated.

Verification
REQ-033 XLEN=32: DIV op1=-7, op2=2 -> result_o=0xFFFFFFFD, valid_o at A+34, rd_o = captured tag; REM same operands -> 0xFFFFFFFF.
REQ-034 DIVU op1=0x1234, op2=0 -> 0xFFFFFFFF at A+1; REMU same operands -> 0x00001234.
REQ-035 DIV op1=0x80000000, op2=0xFFFFFFFF -> 0x80000000; REM -> 0; both at A+1.
REQ-036 MULH op1=0x80000000, op2=0x80000000 -> 0x40000000; MULHSU op1=0xFFFFFFFF, op2=0xFFFFFFFF -> 0xFFFFFFFF; latency A+34, or A+1 with MULDIV_FAST_MUL_EN.
REQ-037 Flush at A+10 of DIVU, then start MUL 3x5 next idle cycle -> no valid_o for the divide, single valid_o with result_o=15.
REQ-038 rst_n pulsed low at A+5 -> outputs zero immediately, no valid_o; start_i held during busy -> ignored, exactly one valid_o.
